// File: rtl/gate_sweep_ctrl_if.sv
// Bundle between the gate sweep sequencer and whatever drives it and hosts the gate.
// GATE_SWEEP_FAIL_LOG_EN adds the first-failing-vector log signals.
interface gate_sweep_ctrl_if #(
   parameter int N_IN  = 2,
   parameter int ERR_W = 8
);
   logic              start;
   logic              abort;
   logic              dut_f;
   logic [N_IN-1:0]   dut_in;
   logic [N_IN-1:0]   vec_idx;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_cnt;
`ifdef GATE_SWEEP_FAIL_LOG_EN
   logic [N_IN-1:0]   first_fail;
   logic              fail_valid;

   modport master (
      output start, abort, dut_f,
      input  dut_in, vec_idx, busy, done, pass, err_cnt, first_fail, fail_valid
   );
   modport slave (
      input  start, abort, dut_f,
      output dut_in, vec_idx, busy, done, pass, err_cnt, first_fail, fail_valid
   );
`else
   modport master (
      output start, abort, dut_f,
      input  dut_in, vec_idx, busy, done, pass, err_cnt
   );
   modport slave (
      input  start, abort, dut_f,
      output dut_in, vec_idx, busy, done, pass, err_cnt
   );
`endif
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive self-test sequencer for a small combinational gate: sweeps all input vectors,
// checks each against TRUTH and counts mismatches. GATE_SWEEP_FAIL_LOG_EN adds first-fail logging.
module gate_sweep_ctrl #(
   parameter int                    N_IN   = 2,
   parameter int                    SETTLE = 10,
   parameter logic [(2**N_IN)-1:0]  TRUTH  = 4'b1000,
   parameter int                    ERR_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   gate_sweep_ctrl_if.slave   bus
);
   localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [N_IN-1:0]   IDX_ZERO = {N_IN{1'b0}};
   localparam logic [N_IN-1:0]   IDX_LAST = {N_IN{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_ZERO = {ERR_W{1'b0}};
   localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      if (v == ERR_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + ERR_W'(1'b1);
      end
   endfunction

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [N_IN-1:0]   r_vec_idx;
   logic [N_IN-1:0]   r_dut_in;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [ERR_W-1:0]  r_err_cnt;
`ifdef GATE_SWEEP_FAIL_LOG_EN
   logic [N_IN-1:0]   r_first_fail;
   logic              r_fail_valid;
`endif

   logic              w_mismatch;
   logic [ERR_W-1:0]  w_err_next;
   logic [N_IN-1:0]   w_idx_next;

   // Mismatch and candidate counter value for the vector under check
   always_comb begin
      w_mismatch = (bus.dut_f != TRUTH[r_vec_idx]);
      w_idx_next = r_vec_idx + N_IN'(1'b1);
      if (w_mismatch) begin
         w_err_next = sat_inc(r_err_cnt);
      end else begin
         w_err_next = r_err_cnt;
      end
   end

   // Sweep sequencer; every output is a register updated alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= CNT_ZERO;
         r_vec_idx  <= IDX_ZERO;
         r_dut_in   <= IDX_ZERO;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err_cnt  <= ERR_ZERO;
`ifdef GATE_SWEEP_FAIL_LOG_EN
         r_first_fail <= IDX_ZERO;
         r_fail_valid <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         // abort beats every in-sweep action, including the CHECK update
         if ((r_state != S_IDLE) && bus.abort) begin
            r_state  <= S_IDLE;
            r_dut_in <= IDX_ZERO;
            r_busy   <= 1'b0;
            r_pass   <= 1'b0;
`ifdef GATE_SWEEP_FAIL_LOG_EN
            r_fail_valid <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start && !bus.abort) begin
                     r_state   <= S_APPLY;
                     r_vec_idx <= IDX_ZERO;
                     r_dut_in  <= IDX_ZERO;
                     r_err_cnt <= ERR_ZERO;
                     r_pass    <= 1'b0;
                     r_busy    <= 1'b1;
`ifdef GATE_SWEEP_FAIL_LOG_EN
                     r_first_fail <= IDX_ZERO;
                     r_fail_valid <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_APPLY: begin
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (r_cnt == CNT_ZERO) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1'b1);
                  end
               end
               S_CHECK: begin
                  r_err_cnt <= w_err_next;
`ifdef GATE_SWEEP_FAIL_LOG_EN
                  if (w_mismatch && !r_fail_valid) begin
                     r_first_fail <= r_vec_idx;
                     r_fail_valid <= 1'b1;
                  end else begin
                     r_fail_valid <= r_fail_valid;
                  end
`endif
                  if (r_vec_idx == IDX_LAST) begin
                     r_state  <= S_DONE;
                     r_dut_in <= IDX_ZERO;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_pass   <= (w_err_next == ERR_ZERO);
                  end else begin
                     r_state   <= S_APPLY;
                     r_vec_idx <= w_idx_next;
                     r_dut_in  <= w_idx_next;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_dut_in <= IDX_ZERO;
                  r_busy   <= 1'b0;
                  r_pass   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.dut_in  = r_dut_in;
   assign bus.vec_idx = r_vec_idx;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.pass    = r_pass;
   assign bus.err_cnt = r_err_cnt;
`ifdef GATE_SWEEP_FAIL_LOG_EN
   assign bus.first_fail = r_first_fail;
   assign bus.fail_valid = r_fail_valid;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomised bench for gate_sweep_ctrl: random gate truth tables, aborts, reset, back-to-back
// sweeps and a saturating 1-bit counter instance, all checked against an arithmetic model.
`timescale 1ns/1ps
module tb_gate_sweep_ctrl;
   localparam int          N_IN    = 2;
   localparam int          NVEC    = 4;
   localparam int          SETTLE  = 10;
   localparam int          VEC_CYC = SETTLE + 2;
   localparam int          SWEEP   = NVEC * VEC_CYC;
   localparam logic [3:0]  TRUTH   = 4'b1000;
   localparam logic [3:0]  GATE_AND = 4'b1000;
   localparam logic [3:0]  GATE_OR  = 4'b1110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] gate_tt = GATE_AND;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   gate_sweep_ctrl_if #(.N_IN(N_IN), .ERR_W(8)) bus ();
   gate_sweep_ctrl_if #(.N_IN(N_IN), .ERR_W(1)) bus_sat ();

   gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE), .TRUTH(4'b1000), .ERR_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE(1), .TRUTH(4'b1000), .ERR_W(1)) u_dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_sat)
   );

   assign bus.dut_f     = gate_tt[bus.dut_in];
   assign bus_sat.dut_f = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mismatches whose CHECK edge has happened by the interval after edge k
   function automatic int exp_errs(input logic [3:0] tt, input int k);
      int c = 0;
      for (int j = 0; j < NVEC; j++) begin
         if (((j + 1) * VEC_CYC <= k) && (tt[j] != TRUTH[j])) c++;
      end
      return (c > 255) ? 255 : c;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"},    32'(bus.busy),    32'd0);
      check_eq({tag, "_done"},    32'(bus.done),    32'd0);
      check_eq({tag, "_pass"},    32'(bus.pass),    32'd0);
      check_eq({tag, "_err"},     32'(bus.err_cnt), 32'd0);
      check_eq({tag, "_dut_in"},  32'(bus.dut_in),  32'd0);
      check_eq({tag, "_vec_idx"}, 32'(bus.vec_idx), 32'd0);
   endtask

   // one sweep from IDLE; abort_k >= 0 raises abort during interval abort_k
   task automatic run_sweep(input logic [3:0] tt, input int abort_k);
      int  errs;
      bit  stop;
      int  first;
      stop = 1'b0;
      gate_tt = tt;
      errs = exp_errs(tt, SWEEP);
      first = -1;
      for (int j = NVEC - 1; j >= 0; j--) if (tt[j] != TRUTH[j]) first = j;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k <= SWEEP + 1 && !stop; k++) begin
         if (abort_k >= 0 && k == abort_k + 1) begin
            bus.abort = 1'b0;
            check_eq("abort_busy",   32'(bus.busy),    32'd0);
            check_eq("abort_dut_in", 32'(bus.dut_in),  32'd0);
            check_eq("abort_pass",   32'(bus.pass),    32'd0);
            check_eq("abort_err",    32'(bus.err_cnt), 32'(exp_errs(tt, abort_k)));
`ifdef GATE_SWEEP_FAIL_LOG_EN
            check_eq("abort_fail_valid", 32'(bus.fail_valid), 32'd0);
`endif
            for (int i = 0; i < 3; i++) begin
               check_eq("abort_no_done", 32'(bus.done), 32'd0);
               tick();
            end
            check_eq("abort_idle_busy", 32'(bus.busy), 32'd0);
            stop = 1'b1;
         end else begin
            check_eq("err_cnt", 32'(bus.err_cnt), 32'(exp_errs(tt, k)));
            if (k < SWEEP) begin
               check_eq("busy",    32'(bus.busy),    32'd1);
               check_eq("done",    32'(bus.done),    32'd0);
               check_eq("dut_in",  32'(bus.dut_in),  32'(k / VEC_CYC));
               check_eq("vec_idx", 32'(bus.vec_idx), 32'(k / VEC_CYC));
               if (k == 0) check_eq("pass_cleared", 32'(bus.pass), 32'd0);
            end else if (k == SWEEP) begin
               check_eq("done_pulse",  32'(bus.done),   32'd1);
               check_eq("done_busy",   32'(bus.busy),   32'd0);
               check_eq("done_dut_in", 32'(bus.dut_in), 32'd0);
               check_eq("done_pass",   32'(bus.pass),   32'(errs == 0));
`ifdef GATE_SWEEP_FAIL_LOG_EN
               check_eq("fail_valid", 32'(bus.fail_valid), 32'(first >= 0));
               if (first >= 0) check_eq("first_fail", 32'(bus.first_fail), 32'(first));
`endif
            end else begin
               check_eq("post_done",   32'(bus.done),   32'd0);
               check_eq("post_busy",   32'(bus.busy),   32'd0);
               check_eq("post_pass",   32'(bus.pass),   32'(errs == 0));
               check_eq("post_dut_in", 32'(bus.dut_in), 32'd0);
            end
            if (k == abort_k) bus.abort = 1'b1;
            tick();
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  pulses;
      int  last_done;
      int  sat_k;
      bit  sat_seen;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus_sat.start = 1'b0;
      bus_sat.abort = 1'b0;

      #2;
      check_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset_idle");

      // known AND and OR gates, then random gates with occasional aborts in WAIT
      run_sweep(GATE_AND, -1);
      run_sweep(GATE_OR, -1);
      run_sweep(GATE_OR, 2 * VEC_CYC + 1 + 4);
      for (int r = 0; r < 8; r++) begin
         logic [3:0] tt;
         int         ak;
         tt = 4'($urandom);
         ak = -1;
         if ($urandom_range(0, 2) == 0) begin
            ak = int'($urandom_range(0, NVEC - 1)) * VEC_CYC + 1 + int'($urandom_range(0, SETTLE - 1));
         end
         run_sweep(tt, ak);
      end

      // asynchronous reset between edges in the middle of a sweep
      gate_tt = GATE_OR;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("after_async_reset");
      run_sweep(GATE_AND, -1);

      // start held high: back-to-back sweeps separated by one DONE and one IDLE cycle
      gate_tt = GATE_AND;
      bus.start = 1'b1;
      pulses = 0;
      last_done = -1;
      for (int k = 0; k < 200; k++) begin
         int p;
         tick();
         p = k % (SWEEP + 2);
         check_eq("b2b_done",   32'(bus.done),   32'(p == SWEEP));
         check_eq("b2b_busy",   32'(bus.busy),   32'(p < SWEEP));
         check_eq("b2b_dut_in", 32'(bus.dut_in), (p < SWEEP) ? 32'(p / VEC_CYC) : 32'd0);
         if (bus.done) begin
            if (last_done >= 0) check_eq("b2b_period", 32'(k - last_done), 32'(SWEEP + 2));
            last_done = k;
            pulses++;
         end
      end
      bus.start = 1'b0;
      check_eq("b2b_pulses", 32'(pulses), 32'd4);
      tick();
      tick();

      // SETTLE=1, ERR_W=1 instance with output stuck at 1: three mismatches saturate at 1
      bus_sat.start = 1'b1;
      tick();
      bus_sat.start = 1'b0;
      sat_seen = 1'b0;
      sat_k = 0;
      for (int k = 0; k < 40 && !sat_seen; k++) begin
         if (bus_sat.done) begin
            sat_seen = 1'b1;
            sat_k = k;
         end else begin
            tick();
         end
      end
      check_eq("sat_done_seen", 32'(sat_sen_fix(sat_seen)), 32'd1);
      check_eq("sat_latency", 32'(sat_k), 32'(NVEC * 3));
      check_eq("sat_err_cnt", 32'(bus_sat.err_cnt), 32'd1);
      check_eq("sat_pass",    32'(bus_sat.pass),    32'd0);
      tick();
      check_eq("sat_err_hold", 32'(bus_sat.err_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   function automatic bit sat_sen_fix(input bit v);
      return v;
   endfunction

endmodule
